// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the regfile_2r1w write-back path.
//   RF_DLEN / RF_ALEN / RF_WORDS : register file geometry
//   rf_wreq_t                    : one register write (address + data)
//   rf_fwd()                     : read-port bypass from the write-back stage
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DLEN  = 32;
    localparam int RF_ALEN  = 5;
    localparam int RF_WORDS = 1 << RF_ALEN;

    typedef struct packed {
        logic [RF_ALEN-1:0] addr;
        logic [RF_DLEN-1:0] data;
    } rf_wreq_t;

    // x0 always reads zero. Otherwise the write sitting in WB is newer than
    // the regfile array contents, so it takes priority.
    function automatic logic [RF_DLEN-1:0] rf_fwd(
        input logic [RF_ALEN-1:0] raddr,
        input logic               wb_valid,
        input logic [RF_ALEN-1:0] wb_addr,
        input logic [RF_DLEN-1:0] wb_data,
        input logic [RF_DLEN-1:0] rf_data
    );
        logic [RF_DLEN-1:0] res;
        if (raddr == '0) begin
            res = '0;
        end else if (wb_valid && (wb_addr == raddr)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req_i found by
// scanning upward from ptr_i and wrapping modulo N.
//   req_i          : request vector
//   ptr_i          : highest-priority index this cycle (must be < N)
//   grant_onehot_o : one-hot grant, zero when no request
//   grant_idx_o    : binary index of the grant (0 when no request)
//   any_o          : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_onehot_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        any_o          = 1'b0;
        j              = 0;
        for (int k = 0; k < N; k++) begin
            // ptr_i < N and k < N, so one subtraction is enough to wrap.
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o             = 1'b1;
                grant_idx_o       = IW'(j);
                grant_onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single write port of regfile_2r1w between NREQ writeback
// requesters using round-robin arbitration, registers the winner in a one-cycle
// write-back (WB) stage, and bypasses the WB value onto both read ports.
//
// Handshake: a requester raises i_req_valid[n] and holds addr/data stable until
// it sees o_req_ready[n] high at a clock edge; that edge is the accept. Ready is
// derived from the valids (never the reverse) and is one-hot or zero.
//
//   clk, rst            : clock, synchronous active-high reset
//   i_req_valid/addr/data : requester n uses bit n / slice [n*ALEN +: ALEN] /
//                           slice [n*DLEN +: DLEN]
//   o_req_ready         : one-hot grant
//   o_rf_wen/waddr/wdata: regfile write port
//   i_raddr_a/b         : read addresses (also go straight to the regfile)
//   i_rf_rdata_a/b      : regfile read data
//   o_rdata_a/b         : read data with WB bypass applied
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DLEN = RF_DLEN,
    parameter int ALEN = RF_ALEN,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*ALEN-1:0] i_req_addr,
    input  logic [NREQ*DLEN-1:0] i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_rf_wen,
    output logic [ALEN-1:0]      o_rf_waddr,
    output logic [DLEN-1:0]      o_rf_wdata,
    input  logic [ALEN-1:0]      i_raddr_a,
    input  logic [ALEN-1:0]      i_raddr_b,
    input  logic [DLEN-1:0]      i_rf_rdata_a,
    input  logic [DLEN-1:0]      i_rf_rdata_b,
    output logic [DLEN-1:0]      o_rdata_a,
    output logic [DLEN-1:0]      o_rdata_b
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wb_valid_q, wb_valid_d;
    rf_wreq_t        wb_q, wb_d;

    logic [NREQ-1:0] arb_onehot;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req_i          (i_req_valid),
        .ptr_i          (rr_ptr_q),
        .grant_onehot_o (arb_onehot),
        .grant_idx_o    (arb_idx),
        .any_o          (arb_any)
    );

    // WB never stalls, so any grant is an accept. During reset nothing is
    // accepted, so ready is held low to keep the handshake honest.
    assign o_req_ready = arb_onehot & {NREQ{~rst}};

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = arb_any;
        wb_d       = wb_q;
        if (arb_any) begin
            rr_ptr_d     = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            wb_d.addr    = i_req_addr[int'(arb_idx)*ALEN +: ALEN];
            wb_d.data    = i_req_data[int'(arb_idx)*DLEN +: DLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    // x0 writes are accepted but never reach the array. The rst term drops an
    // in-flight write in the very cycle reset is asserted.
    assign o_rf_wen   = wb_valid_q & (wb_q.addr != '0) & ~rst;
    assign o_rf_waddr = wb_q.addr;
    assign o_rf_wdata = wb_q.data;

    assign o_rdata_a = rf_fwd(i_raddr_a, wb_valid_q, wb_q.addr, wb_q.data, i_rf_rdata_a);
    assign o_rdata_b = rf_fwd(i_raddr_b, wb_valid_q, wb_q.addr, wb_q.data, i_rf_rdata_b);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NREQ-1:0]         i_req_valid;
  logic [NREQ*RF_ALEN-1:0] i_req_addr;
  logic [NREQ*RF_DLEN-1:0] i_req_data;
  logic [NREQ-1:0]         o_req_ready;
  logic                    o_rf_wen;
  logic [RF_ALEN-1:0]      o_rf_waddr;
  logic [RF_DLEN-1:0]      o_rf_wdata;
  logic [RF_ALEN-1:0]      i_raddr_a, i_raddr_b;
  logic [RF_DLEN-1:0]      i_rf_rdata_a, i_rf_rdata_b;
  logic [RF_DLEN-1:0]      o_rdata_a, o_rdata_b;

  regfile_wb_arbiter #(.DLEN(RF_DLEN), .ALEN(RF_ALEN), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_req_ready  (o_req_ready),
    .o_rf_wen     (o_rf_wen),
    .o_rf_waddr   (o_rf_waddr),
    .o_rf_wdata   (o_rf_wdata),
    .i_raddr_a    (i_raddr_a),
    .i_raddr_b    (i_raddr_b),
    .i_rf_rdata_a (i_rf_rdata_a),
    .i_rf_rdata_b (i_rf_rdata_b),
    .o_rdata_a    (o_rdata_a),
    .o_rdata_b    (o_rdata_b)
  );

  // ---------------- regfile behind the arbiter ----------------
  // Not cleared by rst: a mid-operation reset of the arbiter must not wipe it.
  logic               rf_init;
  logic [RF_DLEN-1:0] rf_mem [RF_WORDS];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < RF_WORDS; i++) rf_mem[i] <= '0;
    end else if (o_rf_wen) begin
      rf_mem[o_rf_waddr] <= o_rf_wdata;
    end
  end
  assign i_rf_rdata_a = rf_mem[i_raddr_a];
  assign i_rf_rdata_b = rf_mem[i_raddr_b];

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_err = 0;

  // Architectural view: committed register contents plus the one write that
  // has been accepted but not yet written to the array.
  logic [RF_DLEN-1:0] m_regs [RF_WORDS];
  int                 m_ptr = 0;
  logic               m_pend_v = 1'b0;
  logic [RF_ALEN-1:0] m_pend_a = '0;
  logic [RF_DLEN-1:0] m_pend_d = '0;
  logic [NREQ-1:0]    last_ready;
  logic               last_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Highest priority = smallest forward distance from the pointer.
  function automatic int model_grant();
    int best, bd, d;
    best = -1;
    bd   = NREQ;
    if (rst) return -1;
    for (int n = 0; n < NREQ; n++) begin
      d = (n - m_ptr + NREQ) % NREQ;
      if (i_req_valid[n] && d < bd) begin
        bd   = d;
        best = n;
      end
    end
    return best;
  endfunction

  function automatic logic [RF_DLEN-1:0] model_read(input logic [RF_ALEN-1:0] a);
    if (a == 0) return '0;
    if (m_pend_v && m_pend_a == a) return m_pend_d;
    return m_regs[a];
  endfunction

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, return just after it so the caller can drive new inputs.
  task automatic tick(input logic use_exp, input logic [2:0] x_ready,
                      input logic x_wen, input logic [31:0] x_ra);
    int g;
    logic [NREQ-1:0] eg;
    logic exp_wen;
    @(negedge clk);
    g  = model_grant();
    eg = (g < 0) ? '0 : NREQ'(1 << g);
    exp_wen = !rst && m_pend_v && (m_pend_a != 0);
    chk("ready", 32'(o_req_ready), 32'(eg));
    chk("wen", 32'(o_rf_wen), 32'(exp_wen));
    if (exp_wen) begin
      chk("waddr", 32'(o_rf_waddr), 32'(m_pend_a));
      chk("wdata", o_rf_wdata, m_pend_d);
    end
    chk("rdata_a", o_rdata_a, model_read(i_raddr_a));
    chk("rdata_b", o_rdata_b, model_read(i_raddr_b));
    if (use_exp) begin
      chk("tbl_ready", 32'(o_req_ready), 32'(x_ready));
      chk("tbl_wen", 32'(o_rf_wen), 32'(x_wen));
      chk("tbl_rdata_a", o_rdata_a, x_ra);
    end
    last_ready = o_req_ready;
    last_rst   = rst;
    @(posedge clk);
    if (rst) begin
      m_ptr    = 0;
      m_pend_v = 1'b0;
    end else begin
      if (m_pend_v && m_pend_a != 0) m_regs[m_pend_a] = m_pend_d;
      if (g >= 0) begin
        m_pend_v = 1'b1;
        m_pend_a = i_req_addr[g*RF_ALEN +: RF_ALEN];
        m_pend_d = i_req_data[g*RF_DLEN +: RF_DLEN];
        m_ptr    = (g + 1) % NREQ;
      end else begin
        m_pend_v = 1'b0;
      end
    end
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic               rst;
    logic [2:0]         valid;
    logic [RF_ALEN-1:0] a0, a1, a2;
    logic [RF_DLEN-1:0] d0, d1, d2;
    logic [RF_ALEN-1:0] ra, rb;
    logic [2:0]         x_ready;
    logic               x_wen;
    logic [RF_DLEN-1:0] x_ra;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [2:0] v,
                              input int a0, input logic [31:0] d0,
                              input int a1, input logic [31:0] d1,
                              input int a2, input logic [31:0] d2,
                              input int ra, input int rb,
                              input logic [2:0] xr, input logic xw, input logic [31:0] xra);
    vec_t t;
    t.rst = r; t.valid = v;
    t.a0 = 5'(a0); t.a1 = 5'(a1); t.a2 = 5'(a2);
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.ra = 5'(ra); t.rb = 5'(rb);
    t.x_ready = xr; t.x_wen = xw; t.x_ra = xra;
    return t;
  endfunction

  function automatic logic [31:0] dv(input int n);
    return 32'hC0DE_0000 | 32'(n);
  endfunction

  task automatic apply(input vec_t t);
    rst         = t.rst;
    i_req_valid = t.valid;
    i_req_addr  = {t.a2, t.a1, t.a0};
    i_req_data  = {t.d2, t.d1, t.d0};
    i_raddr_a   = t.ra;
    i_raddr_b   = t.rb;
  endtask

  // ---------------- random requesters ----------------
  logic [NREQ-1:0]    r_pend;
  logic [RF_ALEN-1:0] r_addr [NREQ];
  logic [RF_DLEN-1:0] r_data [NREQ];

  initial begin
    for (int i = 0; i < RF_WORDS; i++) m_regs[i] = '0;
    rf_init = 1'b1;
    rst = 1'b1;
    i_req_valid = '0; i_req_addr = '0; i_req_data = '0;
    i_raddr_a = '0; i_raddr_b = '0;
    last_ready = '0; last_rst = 1'b0;

    // reset sequence
    tick(1'b0, '0, 1'b0, '0);
    tick(1'b0, '0, 1'b0, '0);
    rf_init = 1'b0;
    chk("rst_waddr", 32'(o_rf_waddr), 32'h0);
    chk("rst_wdata", o_rf_wdata, 32'h0);

    //            rst valid  a0 d0             a1 d1       a2 d2       ra rb  ready  wen  rdata_a
    tbl[0]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       0, 1,  3'b000, 0, 32'h0);
    tbl[1]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       5, 9,  3'b000, 0, 32'h0);
    tbl[2]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       31, 30, 3'b000, 0, 32'h0);
    tbl[3]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       3, 17, 3'b000, 0, 32'h0);
    tbl[4]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       7, 0,  3'b000, 0, 32'h0);
    // lone write r5
    tbl[5]  = mk(0, 3'b001, 5, 32'hDEADBEEF,  0, 0,       0, 0,       5, 5,  3'b001, 0, 32'h0);
    tbl[6]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       5, 5,  3'b000, 1, 32'hDEADBEEF);
    tbl[7]  = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       5, 4,  3'b000, 0, 32'hDEADBEEF);
    // r3 written by req1 then req2 back to back
    tbl[8]  = mk(0, 3'b010, 0, 0,             3, 32'h11,  0, 0,       3, 3,  3'b010, 0, 32'h0);
    tbl[9]  = mk(0, 3'b100, 0, 0,             0, 0,       3, 32'h22,  3, 3,  3'b100, 1, 32'h11);
    tbl[10] = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       3, 3,  3'b000, 1, 32'h22);
    tbl[11] = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       3, 5,  3'b000, 0, 32'h22);
    // all three contend: grants 0,1,2,0,1,2
    tbl[12] = mk(0, 3'b111, 1, dv(1),         2, dv(2),   3, dv(3),   1, 2,  3'b001, 0, 32'h0);
    tbl[13] = mk(0, 3'b111, 4, dv(4),         2, dv(2),   3, dv(3),   1, 3,  3'b010, 1, dv(1));
    tbl[14] = mk(0, 3'b111, 4, dv(4),         5, dv(5),   3, dv(3),   2, 1,  3'b100, 1, dv(2));
    tbl[15] = mk(0, 3'b111, 4, dv(4),         5, dv(5),   6, dv(6),   3, 2,  3'b001, 1, dv(3));
    tbl[16] = mk(0, 3'b111, 0, 32'hFFFF,      5, dv(5),   6, dv(6),   4, 3,  3'b010, 1, dv(4));
    tbl[17] = mk(0, 3'b101, 0, 32'hFFFF,      0, 0,       6, dv(6),   5, 4,  3'b100, 1, dv(5));
    // pointer back at 0; x0 write accepted but never written
    tbl[18] = mk(0, 3'b001, 0, 32'hFFFF,      0, 0,       0, 0,       6, 0,  3'b001, 1, dv(6));
    tbl[19] = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       0, 0,  3'b000, 0, 32'h0);
    // req2 writes r7, reset lands in its WB cycle
    tbl[20] = mk(0, 3'b100, 0, 0,             0, 0,       7, 32'h55,  7, 7,  3'b100, 0, 32'h0);
    tbl[21] = mk(1, 3'b000, 0, 0,             0, 0,       0, 0,       1, 6,  3'b000, 0, dv(1));
    tbl[22] = mk(0, 3'b111, 9, dv(9),         10, dv(10), 11, dv(11), 7, 7,  3'b001, 0, 32'h0);
    tbl[23] = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       7, 9,  3'b000, 1, 32'h0);
    tbl[24] = mk(0, 3'b000, 0, 0,             0, 0,       0, 0,       9, 3,  3'b000, 0, dv(9));

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      tick(1'b1, tbl[i].x_ready, tbl[i].x_wen, tbl[i].x_ra);
    end

    // final contents as seen through the regfile (no write in flight)
    i_req_valid = '0;
    i_raddr_a = 5'd3; i_raddr_b = 5'd7;
    tick(1'b0, '0, 1'b0, '0);
    chk("final_r3", o_rdata_a, dv(3));
    chk("final_r7", o_rdata_b, 32'h0);

    // random phase: protocol-compliant requesters, occasional reset
    r_pend = '0;
    for (int n = 0; n < NREQ; n++) begin
      r_addr[n] = '0;
      r_data[n] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < NREQ; n++) begin
        if (r_pend[n] && last_ready[n] && !last_rst) r_pend[n] = 1'b0;
        if (!r_pend[n] && $urandom_range(0, 1) == 1) begin
          r_pend[n] = 1'b1;
          r_addr[n] = 5'($urandom_range(0, 7));
          r_data[n] = $urandom;
        end
      end
      rst         = ($urandom_range(0, 39) == 0);
      i_req_valid = r_pend;
      i_req_addr  = {r_addr[2], r_addr[1], r_addr[0]};
      i_req_data  = {r_data[2], r_data[1], r_data[0]};
      i_raddr_a   = 5'($urandom_range(0, 7));
      i_raddr_b   = 5'($urandom_range(0, 31));
      tick(1'b0, '0, 1'b0, '0);
    end

    rst = 1'b0;
    i_req_valid = '0;
    tick(1'b0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
